// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between the hazard/E stage and md_unit
// Ports:
//   Start   one-cycle request pulse, qualified by MDOp
//   MDOp    0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 no-op
//   A, B    rs / rt operands
//   HILOSel read select for Out (1 HI, 0 LO)
//   Busy    operation in progress
//   HI, LO  architectural HI/LO registers
//   Out     HILOSel ? HI : LO, combinational
interface md_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HILOSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    modport master (
        output Start, MDOp, A, B, HILOSel,
        input  Busy, HI, LO, Out
    );

    modport slave (
        input  Start, MDOp, A, B, HILOSel,
        output Busy, HI, LO, Out
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous active-low reset
//   md     md_unit_if.slave: Start/MDOp/A/B/HILOSel in, Busy/HI/LO/Out out
// Parameters:
//   MULT_CYCLES  Busy duration for mult/multu (1..63)
//   DIV_CYCLES   Busy duration for div/divu (1..63)
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    md_unit_if.slave    md
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;       // pending result is committed on completion
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // ---------------------------------------------------------------
    // Arithmetic, evaluated on the operands presented with Start
    // ---------------------------------------------------------------
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_s_den, div_u_den;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    always_comb begin
        // Sign-extended 64-bit operands: the low 64 bits of the product are
        // the exact two's-complement signed product.
        prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
        prod_u = {32'd0, md.A} * {32'd0, md.B};

        // Signed divide done on magnitudes so that 0x80000000 / -1 simply
        // wraps to 0x80000000 with remainder 0 instead of overflowing.
        a_neg = md.A[31];
        b_neg = md.B[31];
        a_mag = a_neg ? (32'd0 - md.A) : md.A;
        b_mag = b_neg ? (32'd0 - md.B) : md.B;

        // A zero divisor never commits a result; substitute 1 so the
        // dividers always see a defined operand.
        div_s_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        div_u_den = (md.B == 32'd0) ? 32'd1 : md.B;

        q_mag = a_mag / div_s_den;
        r_mag = a_mag % div_s_den;
        q_s   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_s   = a_neg ? (32'd0 - r_mag) : r_mag;

        q_u   = md.A / div_u_den;
        r_u   = md.A % div_u_den;
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (md.Start) begin
                    case (md_op_e'(md.MDOp))
                        OP_MULT: begin
                            pend_d  = prod_s;
                            wr_d    = 1'b1;
                            cnt_d   = 6'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_d  = prod_u;
                            wr_d    = 1'b1;
                            cnt_d   = 6'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV: begin
                            pend_d  = {r_s, q_s};
                            wr_d    = (md.B != 32'd0);
                            cnt_d   = 6'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_d  = {r_u, q_u};
                            wr_d    = (md.B != 32'd0);
                            cnt_d   = 6'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = md.A;
                        OP_MTLO: lo_d = md.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Start is deliberately not looked at while running.
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_IDLE;
                    if (wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            wr_q    <= 1'b0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.Busy = (cnt_q != 6'd0);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
    assign md.Out  = md.HILOSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - table-driven scoreboard bench for md_unit
module tb_md_unit;

    logic clk;
    logic rst_n;

    md_unit_if m ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .md    (m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request, follow Busy until it drops, then compare with the
    // scoreboard entry pushed at drive time. inject=1 pulses mult and mthi
    // requests during busy cycles 3 and 4; both must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int ec,
                          input bit inject, input string tag);
        exp_t e;
        int   n;
        bit   held;
        m.Start = 1'b1;
        m.MDOp  = op;
        m.A     = a;
        m.B     = b;
        e.hi = eh; e.lo = el; e.cycles = ec;
        sbq.push_back(e);
        @(posedge clk); #1;
        m.Start = 1'b0;
        n    = 0;
        held = 1'b1;
        while (m.Busy && n < 200) begin
            if (m.HI !== prev_hi || m.LO !== prev_lo) held = 1'b0;
            n++;
            if (inject && n == 3) begin
                m.Start = 1'b1; m.MDOp = 3'd1; m.A = 32'h0000_0009; m.B = 32'h0000_0009;
            end else if (inject && n == 4) begin
                m.Start = 1'b1; m.MDOp = 3'd5; m.A = 32'hDEAD_BEEF;
            end else begin
                m.Start = 1'b0;
            end
            @(posedge clk); #1;
        end
        m.Start = 1'b0;
        e = sbq.pop_front();
        check({tag, " busy_cycles"}, 64'(n), 64'(e.cycles));
        check({tag, " HI"}, 64'(m.HI), 64'(e.hi));
        check({tag, " LO"}, 64'(m.LO), 64'(e.lo));
        if (n > 0) check({tag, " held_while_busy"}, 64'(held), 64'd1);
        m.HILOSel = 1'b1; #1;
        check({tag, " Out_hi"}, 64'(m.Out), 64'(e.hi));
        m.HILOSel = 1'b0; #1;
        check({tag, " Out_lo"}, 64'(m.Out), 64'(e.lo));
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10};
        vecs[4]  = '{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 0};
        vecs[5]  = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 10};
        vecs[6]  = '{3'd5, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 32'h1234_5678, 0};
        vecs[7]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[8]  = '{3'd0, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[9]  = '{3'd7, 32'h3333_3333, 32'h4444_4444, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[10] = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[11] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[12] = '{3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[13] = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[14] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};

        m.Start   = 1'b0;
        m.MDOp    = 3'd0;
        m.A       = 32'd0;
        m.B       = 32'd0;
        m.HILOSel = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("reset Busy", 64'(m.Busy), 64'd0);
        check("reset HI", 64'(m.HI), 64'd0);
        check("reset LO", 64'(m.LO), 64'd0);
        check("reset Out", 64'(m.Out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].exp_cycles, 1'b0, $sformatf("vec%0d", i));

        // Requests arriving mid-divide are dropped: 100 / 7 = 14 rem 2.
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1, "ignore_in_run");

        // Reset during busy cycle 4 of a mult: clears immediately, no late write.
        m.Start = 1'b1; m.MDOp = 3'd1; m.A = 32'd3; m.B = 32'd4;
        @(posedge clk); #1;
        m.Start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrun Busy_before_reset", 64'(m.Busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun reset Busy", 64'(m.Busy), 64'd0);
        check("midrun reset HI", 64'(m.HI), 64'd0);
        check("midrun reset LO", 64'(m.LO), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("post_reset Busy", 64'(m.Busy), 64'd0);
        check("post_reset HI", 64'(m.HI), 64'd0);
        check("post_reset LO", 64'(m.LO), 64'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0, "after_reset_mult");

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide responder for the pipelined MIPS core. It accepts a one-cycle `Start` request with operands from the E stage and holds `Busy` high for the operation's latency. It writes the 64-bit result into the architectural HI/LO registers and offers a combinational HI/LO read port. The hazard unit drives `Start` and watches `Busy` to stall D-stage mult/div/mfhi/mflo instructions.

## Interface
- `MULT_CYCLES`, default 5: Busy duration for mult/multu.
- `DIV_CYCLES`, default 10: Busy duration for div/divu.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  reset; one clock; reset is asynchronous and active-low.
- `Start`  in  1  one-cycle request pulse, qualified by `MDOp`.
- `MDOp`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- `A`  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- `B`  in  32  rt operand (divisor / multiplier).
- `HILOSel`  in  1  read select: 1 HI, 0 LO.
- `Busy`  out  1  operation in progress.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `Out`  out  32  `HILOSel ? HI : LO`, combinational.

## Operation
- State: IDLE (cnt==0) and RUN (cnt!=0).
- Registers: 6-bit down-counter `cnt`, latched op kind, 64-bit pending result.
- `Busy` = (cnt != 0), registered-derived, no combinational path from `Start`.
- IDLE, `Start`, MDOp 1–4:
  - Compute the result from A/B at that edge and hold it in the pending register.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- IDLE, `Start`, MDOp 5/6: write A to HI (5) or LO (6) at that edge. `Busy` stays 0.
- IDLE, `Start`, MDOp 0/7: no effect.
- RUN:
  - Decrement `cnt` each edge.
  - On the edge where cnt goes 1→0, copy the pending result to {HI,LO}. Go to IDLE.
- `Start` while RUN: ignored entirely (including mthi/mtlo). The hazard unit guarantees this does not occur; the bench checks that it is ignored.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), full 64 bits.
  - multu: unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the dividend's sign.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu, B==0): full DIV_CYCLES busy, then HI/LO unchanged.
- Reset asserted at any time, including mid-RUN: cnt=0, Busy=0, HI=0, LO=0, pending result discarded. Outputs are valid asynchronously on assertion.

## Timing
- Reset values: Busy 0, HI 0x00000000, LO 0x00000000. `Out` = 0.
- `Start` sampled at edge t (mult):
  - Busy=1 in cycles t+1 … t+MULT_CYCLES.
  - New HI/LO visible after edge t+MULT_CYCLES, when Busy has returned to 0.
- Div: same timing with DIV_CYCLES.
- A new `Start` is accepted at the first edge where Busy==0, giving back-to-back operations with no bubble.
- mthi/mtlo: HI/LO updated after edge t. A read in cycle t+1 sees the new value.
- `Out` follows `HILOSel` and HI/LO with zero cycles of latency.
- Deassertion of reset: the first accepted `Start` is at the first rising edge with Reset high.

## Test plan
- Reset, then mult A=0xFFFFFFFE (-2), B=3:
  - Busy high exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO stay 0 while busy.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2:
  - Busy 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then divu with same operands: LO=0x7FFFFFFC, HI=1.
- mtlo 0x12345678 while idle:
  - LO updates next cycle, Busy stays 0.
  - Start div A=5, B=0 → 10 busy cycles, LO still 0x12345678, HI unchanged.
- During a div, pulse Start mult and mthi at cycles 3 and 4 → both ignored; div result only.
- Assert Reset at busy cycle 4 of a mult → Busy, HI, LO immediately 0. No late write after release.
